// File: rtl/video_pixel_sink.sv
// Pixel FIFO between the display-plane pipeline and the video output. It pops one pixel per active
// new_pixel strobe and realigns each line to the raster using the end-of-line tag.
module video_pixel_sink #(
  parameter int DEPTH = 64,
  parameter int DW    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_in_valid,
  output logic                     pix_in_ready,
  input  logic [DW-1:0]            pix_in_data,
  input  logic                     pix_in_eol,
  input  logic                     new_pixel,
  input  logic                     new_line,
  input  logic                     hblank,
  input  logic                     vblank,
  input  logic [DW-1:0]            border_rgb,
  output logic                     line_req,
  output logic [DW-1:0]            rgb_out,
  output logic                     rgb_strobe,
  output logic                     underflow,
  input  logic                     underflow_clr,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_LINE_WAIT = 2'd0;
  localparam logic [1:0] S_ACTIVE    = 2'd1;
  localparam logic [1:0] S_TAIL      = 2'd2;
  localparam logic [1:0] S_DISCARD   = 2'd3;

  logic [DW:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic            r_hblank_d;
  logic            r_vblank_d;
  logic            r_flush_q;
  logic            r_overrun;
  logic            r_underflow;
  logic            r_line_req;
  logic            r_strobe;
  logic [DW-1:0]   r_rgb;

  logic            w_empty;
  logic            w_full;
  logic            w_wr;
  logic            w_pop;
  logic            w_hb_rise;
  logic            w_hb_fall;
  logic            w_vb_rise;
  logic            w_start;
  logic            w_active;
  logic [DW:0]     w_head;
  logic            w_head_eol;
  logic            w_pix_pop;
  logic            w_pix_under;
  logic            w_disc_pop;
  logic            w_overrun_now;
  logic            w_border_px;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign pix_in_ready = !w_full && !r_flush_q;
  assign w_wr         = pix_in_valid && pix_in_ready;

  assign w_hb_rise = hblank && !r_hblank_d;
  assign w_hb_fall = !hblank && r_hblank_d;
  assign w_vb_rise = vblank && !r_vblank_d;

  // A line may start in the same cycle the hblank fall is seen, so its first pixel is not lost.
  assign w_start    = (r_state == S_LINE_WAIT) && w_hb_fall && !vblank;
  assign w_active   = (r_state == S_ACTIVE) || w_start;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_eol = w_head[DW];

  assign w_pix_pop     = w_active && new_pixel && !w_empty;
  assign w_pix_under   = w_active && new_pixel && w_empty;
  assign w_disc_pop    = (r_state == S_DISCARD) && !w_empty;
  assign w_pop         = !r_flush_q && (w_pix_pop || w_disc_pop);
  assign w_overrun_now = (r_state == S_DISCARD) && w_hb_fall && !vblank && !r_overrun;
  assign w_border_px   = new_pixel && ((r_state == S_TAIL) ||
                         ((r_state == S_DISCARD) && (r_overrun || w_hb_fall)));

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {pix_in_eol, pix_in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_flush_q) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // An overrun line that finishes its discard mid-line continues in TAIL, emitting border colour.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LINE_WAIT: begin
        if (w_start) begin
          w_state_next = (w_pix_pop && w_head_eol) ? S_TAIL : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_pix_pop && w_head_eol) begin
          w_state_next = S_TAIL;
        end else if (w_hb_rise) begin
          w_state_next = S_DISCARD;
        end
      end
      S_TAIL: begin
        if (w_hb_rise) begin
          w_state_next = S_LINE_WAIT;
        end
      end
      default: begin
        if (w_disc_pop && w_head_eol) begin
          w_state_next = ((r_overrun && !w_hb_rise) || (w_hb_fall && !vblank)) ? S_TAIL : S_LINE_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LINE_WAIT;
      r_hblank_d <= 1'b0;
      r_vblank_d <= 1'b0;
      r_flush_q  <= 1'b0;
      r_overrun  <= 1'b0;
      r_line_req <= 1'b0;
    end else begin
      r_state    <= r_flush_q ? S_LINE_WAIT : w_state_next;
      r_hblank_d <= hblank;
      r_vblank_d <= vblank;
      r_flush_q  <= w_vb_rise;
      r_line_req <= new_line && !vblank;
      if (r_flush_q || (r_state != S_DISCARD) || w_hb_rise) begin
        r_overrun <= 1'b0;
      end else if (w_hb_fall && !vblank) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Set has priority over clear so a fresh underflow is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (w_pix_under || w_overrun_now) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb    <= '0;
      r_strobe <= 1'b0;
    end else if (hblank || vblank) begin
      r_rgb    <= '0;
      r_strobe <= 1'b0;
    end else if (w_pix_pop) begin
      r_rgb    <= w_head[DW-1:0];
      r_strobe <= 1'b1;
    end else if (w_pix_under || w_border_px) begin
      r_rgb    <= border_rgb;
      r_strobe <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign line_req   = r_line_req;
  assign rgb_out    = r_rgb;
  assign rgb_strobe = r_strobe;
  assign underflow  = r_underflow;
  assign fill_level = r_count;

endmodule
